imm_gen_pipe: RTL
=================

// Module: imm_gen_pipe
// PURPOSE
//  Parametrised, registered immediate generator for the ID stage of the pipelined core.
//  Decodes I/S/B/J/U/shamt immediates from a fetched instruction and sign-/zero-extends to XLEN.
//  Replaces the combinational 2-bit extender: 3-bit format select, 64-bit support, illegal-format flag.
//  Valid/ready handshake with 2-entry skid buffer, so IF/ID back-pressure never drops an instruction.
// PARAMETERS
//  XLEN   32  datapath width; legal values 32, 64 only (elaboration $error otherwise)
//  TAG_W  32  sideband carried alongside each immediate (typically PC), passed unchanged
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high; clears all state
//  flush      in   1       synchronous kill of buffered entries (branch mispredict)
//  in_valid   in   1       instr/imm_src/in_tag valid this cycle
//  in_ready   out  1       block can accept; transfer when in_valid && in_ready
//  instr      in   25      instruction bits [31:7]
//  imm_src    in   3       format select, see BEHAVIOUR
//  in_tag     in   TAG_W   sideband
//  out_valid  out  1       imm_ext/out_tag/illegal valid
//  out_ready  in   1       consumer accepts; transfer when out_valid && out_ready
//  imm_ext    out  XLEN    extended immediate
//  out_tag    out  TAG_W   sideband of the same instruction
//  illegal    out  1       imm_src was 110/111 for this entry
// BEHAVIOUR
//  Formats (s = instr[31] replicated to XLEN):
//   000 I  {s,instr[31:20]}                 001 S  {s,instr[31:25],instr[11:7]}
//   010 B  {s,instr[7],instr[30:25],instr[11:8],0}
//   011 J  {s,instr[19:12],instr[20],instr[30:21],0}
//   100 U  {s above bit31 (XLEN=64 only),instr[31:12],12'b0}
//   101 SH zero-ext instr[24:20] (XLEN=32) / instr[25:20] (XLEN=64)
//   110/111  imm_ext=0, illegal=1; entry still flows (trap raised downstream)
//  Decode is combinational on input; result captured into output register; latency 1 cycle.
//  Storage: output reg (out_valid) + skid reg (skid_valid). in_ready = !skid_valid (registered).
//  Per cycle, acc = in_valid&&in_ready, pop = out_valid&&out_ready:
//   - out empty or pop: out <- skid if skid_valid, else decoded input if acc; skid_valid<=0 if moved
//   - out full and !pop and acc: decoded input -> skid; skid_valid<=1 (in_ready drops next cycle)
//   - pop with skid empty and !acc: out_valid<=0
//  Order preserved: an entry accepted on cycle N never overtakes one accepted earlier.
//  Simultaneous acc+pop with skid full impossible (in_ready=0). acc+pop with skid empty: out reloads, no bubble.
//  Throughput 1/cycle while out_ready held high.
//  out_* and illegal are stable while out_valid && !out_ready.
//  flush: out_valid<=0, skid_valid<=0; any in_valid that cycle is discarded; in_ready=1 next cycle.
//  flush has priority over acc/pop in the same cycle.
//  reset (async): out_valid=0, skid_valid=0, in_ready=1, imm_ext=0, out_tag=0, illegal=0.
//  Reset mid-transfer drops all buffered entries; no output until new in_valid after release.
//  Data registers do not need flush clear; only valid bits are required to clear.
// TESTING
//  I: instr[31:7] of 0xFFF00093, imm_src=000 -> imm_ext=0xFFFFFFFF one cycle later, illegal=0
//  S/B/J/U, XLEN=32: 0xFE20AE23 S -> 0xFFFFFFFC; 0xFE000CE3 B -> 0xFFFFFFF8;
//   0x0010006F J -> 0x00000800; 0x123450B7 U -> 0x12345000
//  XLEN=64: 0x800000B7 U -> 0xFFFFFFFF80000000; SH with instr[25:20]=63 -> 0x3F
//  Back-pressure: stream 8 tagged entries, out_ready low 3 cycles mid-stream ->
//   in_ready low after 2 held entries, all 8 emerge in order, none duplicated/lost
//  imm_src=111 -> illegal=1, imm_ext=0, tag preserved; flush with both regs full ->
//   out_valid=0 next cycle, in_ready=1, flushed tags never appear
//  Assert reset asynchronously mid-stream -> outputs zero immediately; stream restarts cleanly

Source files
------------

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//   Registered immediate generator for the ID stage. Decodes the I/S/B/J/U/shamt
//   immediate from instruction bits [31:7], sign- or zero-extends it to XLEN and
//   holds the result in an output register. A second (skid) register absorbs
//   one extra entry so in_ready can be a pure register output and back-pressure
//   never drops an instruction. A sideband tag (typically the PC) travels with
//   each entry unchanged.
//
// Parameters
//   XLEN   datapath width, 32 or 64
//   TAG_W  sideband width
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high; clears all state
//   flush      in   synchronous kill of both buffered entries and of this cycle's input
//   in_valid   in   instr/imm_src/in_tag valid
//   in_ready   out  block can accept (registered, = no entry parked in skid)
//   instr      in   instruction bits [31:7]
//   imm_src    in   format: 000 I, 001 S, 010 B, 011 J, 100 U, 101 shamt, 11x illegal
//   in_tag     in   sideband
//   out_valid  out  imm_ext/out_tag/illegal valid
//   out_ready  in   consumer accepts
//   imm_ext    out  extended immediate
//   out_tag    out  sideband of the same instruction
//   illegal    out  imm_src was 110/111 for this entry
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [24:0]      instr,
   input  logic [2:0]       imm_src,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm_ext,
   output logic [TAG_W-1:0] out_tag,
   output logic             illegal
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
   end

   // Re-index the 25 input bits with their instruction bit numbers so the
   // format slices below read exactly like the ISA encoding tables.
   logic [31:7] ins;
   assign ins = instr;

   // ---------------------------------------------------------------------------
   // Combinational decode of the incoming instruction
   // ---------------------------------------------------------------------------
   logic [XLEN-1:0] dec_imm;
   logic            dec_ill;

   // NOTE: every signal written in an always_comb gets a default first; a path
   // that leaves one unassigned would infer a latch.
   always_comb begin
      dec_imm = '0;
      dec_ill = 1'b0;
      case (imm_src)
         3'b000:  dec_imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
         3'b001:  dec_imm = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
         3'b010:  dec_imm = {{(XLEN-12){ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
         3'b011:  dec_imm = {{(XLEN-20){ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
         // U: bit 31 of the result is ins[31] itself, copies above it only for XLEN=64.
         3'b100:  dec_imm = {{(XLEN-31){ins[31]}}, ins[30:12], 12'b0};
         // Shift amount: 5 bits on RV32, 6 bits on RV64, always zero-extended.
         3'b101:  dec_imm = {{(XLEN-6){1'b0}}, ((XLEN == 64) ? ins[25] : 1'b0), ins[24:20]};
         default: dec_ill = 1'b1;   // 110/111: immediate stays 0, entry still flows
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output register + skid register
   // ---------------------------------------------------------------------------
   logic             out_valid_q, out_valid_d;
   logic [XLEN-1:0]  out_imm_q,   out_imm_d;
   logic [TAG_W-1:0] out_tag_q,   out_tag_d;
   logic             out_ill_q,   out_ill_d;

   logic             skid_valid_q, skid_valid_d;
   logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
   logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
   logic             skid_ill_q,   skid_ill_d;

   logic acc;
   logic pop;

   assign in_ready = !skid_valid_q;
   assign acc      = in_valid && in_ready;
   assign pop      = out_valid_q && out_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_imm_d    = out_imm_q;
      out_tag_d    = out_tag_q;
      out_ill_d    = out_ill_q;
      skid_valid_d = skid_valid_q;
      skid_imm_d   = skid_imm_q;
      skid_tag_d   = skid_tag_q;
      skid_ill_d   = skid_ill_q;

      if (flush) begin
         // Only the valid bits are killed; stale payload is never observed.
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || pop) begin
         // Output slot frees up: the older skid entry goes first. acc cannot
         // happen while skid is full, so nothing is lost in that branch.
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_imm_d    = skid_imm_q;
            out_tag_d    = skid_tag_q;
            out_ill_d    = skid_ill_q;
            skid_valid_d = 1'b0;
         end else if (acc) begin
            out_valid_d = 1'b1;
            out_imm_d   = dec_imm;
            out_tag_d   = in_tag;
            out_ill_d   = dec_ill;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (acc) begin
         // Output stalled: park the new entry; in_ready drops next cycle.
         skid_valid_d = 1'b1;
         skid_imm_d   = dec_imm;
         skid_tag_d   = in_tag;
         skid_ill_d   = dec_ill;
      end
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge value of the others regardless of statement order.
   // The payload registers are reset as well: outputs must read zero during
   // reset, and a known skid payload keeps X out of the datapath.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         out_imm_q    <= '0;
         out_tag_q    <= '0;
         out_ill_q    <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_imm_q   <= '0;
         skid_tag_q   <= '0;
         skid_ill_q   <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_imm_q    <= out_imm_d;
         out_tag_q    <= out_tag_d;
         out_ill_q    <= out_ill_d;
         skid_valid_q <= skid_valid_d;
         skid_imm_q   <= skid_imm_d;
         skid_tag_q   <= skid_tag_d;
         skid_ill_q   <= skid_ill_d;
      end
   end

   assign out_valid = out_valid_q;
   assign imm_ext   = out_imm_q;
   assign out_tag   = out_tag_q;
   assign illegal   = out_ill_q;

endmodule
